// File: rtl/seq_adder.sv
// seq_adder: multi-cycle chunked ripple adder/subtractor with valid/ready handshakes
module seq_adder #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             Cin_i,
  input  logic             sub_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] s_o,
  output logic             Cout_o,
  output logic             ovf_o
);
  localparam int N = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  if (CHUNK < 1 || CHUNK > WIDTH || WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("seq_adder: CHUNK must be in 1..WIDTH and divide WIDTH");
  end
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, psum_q, psum_d, s_q, s_d, psum_nx;
  logic carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d, last;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CHUNK-1:0] sum;
  logic [CHUNK:0] c;
  // Ripple CHUNK full-adder cells across the low bits of the operand registers
  always_comb begin
    sum = '0;
    c = '0;
    c[0] = carry_q;
    for (int i = 0; i < CHUNK; i++) begin
      sum[i] = a_q[i] ^ b_q[i] ^ c[i];
      c[i+1] = (a_q[i] & b_q[i]) | (c[i] & (a_q[i] ^ b_q[i]));
    end
  end
  assign psum_nx = (psum_q >> CHUNK) | (WIDTH'(sum) << (WIDTH - CHUNK));
  assign last = cnt_q == LAST;
  // Next-state and datapath updates; outputs are only loaded on the final chunk
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    carry_d = carry_q;
    cnt_d = cnt_q;
    psum_d = psum_q;
    s_d = s_q;
    cout_d = cout_q;
    ovf_d = ovf_q;
    case (state_q)
      IDLE: if (in_valid_i) begin
        state_d = CALC;
        a_d = a_i;
        b_d = sub_i ? ~b_i : b_i;
        carry_d = sub_i | Cin_i;
        cnt_d = '0;
      end
      CALC: begin
        state_d = last ? DONE : CALC;
        a_d = a_q >> CHUNK;
        b_d = b_q >> CHUNK;
        carry_d = c[CHUNK];
        cnt_d = cnt_q + CW'(1);
        psum_d = psum_nx;
        s_d = last ? psum_nx : s_q;
        cout_d = last ? c[CHUNK] : cout_q;
        ovf_d = last ? c[CHUNK-1] ^ c[CHUNK] : ovf_q;
      end
      DONE: state_d = out_ready_i ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  // State and datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      carry_q <= 1'b0;
      cnt_q <= '0;
      psum_q <= '0;
      s_q <= '0;
      cout_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      carry_q <= carry_d;
      cnt_q <= cnt_d;
      psum_q <= psum_d;
      s_q <= s_d;
      cout_q <= cout_d;
      ovf_q <= ovf_d;
    end
  end
  assign in_ready_o = state_q == IDLE;
  assign out_valid_o = state_q == DONE;
  assign s_o = s_q;
  assign Cout_o = cout_q;
  assign ovf_o = ovf_q;
endmodule

// File: tb/tb_seq_adder.sv
// tb_seq_adder: scoreboard bench for seq_adder at CHUNK=2, 8 and 1
module tb_seq_adder;
  typedef struct packed {logic [7:0] s; logic c; logic v;} res_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic cin = 1'b0, sub = 1'b0, out_ready = 1'b1;
  logic in_valid [3];
  logic in_ready [3];
  logic out_valid [3];
  logic [7:0] s [3];
  logic cout [3];
  logic ovf [3];
  int nn [3] = '{4, 1, 8};
  int checks = 0, errors = 0, cyc = 0, acc_cyc = 0, prev_acc = 0;
  res_t sb [$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  seq_adder #(.WIDTH(8), .CHUNK(2)) u_c2 (.clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid[0]),
    .in_ready_o(in_ready[0]), .a_i(a), .b_i(b), .Cin_i(cin), .sub_i(sub), .out_valid_o(out_valid[0]),
    .out_ready_i(out_ready), .s_o(s[0]), .Cout_o(cout[0]), .ovf_o(ovf[0]));
  seq_adder #(.WIDTH(8), .CHUNK(8)) u_c8 (.clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid[1]),
    .in_ready_o(in_ready[1]), .a_i(a), .b_i(b), .Cin_i(cin), .sub_i(sub), .out_valid_o(out_valid[1]),
    .out_ready_i(out_ready), .s_o(s[1]), .Cout_o(cout[1]), .ovf_o(ovf[1]));
  seq_adder #(.WIDTH(8), .CHUNK(1)) u_c1 (.clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid[2]),
    .in_ready_o(in_ready[2]), .a_i(a), .b_i(b), .Cin_i(cin), .sub_i(sub), .out_valid_o(out_valid[2]),
    .out_ready_i(out_ready), .s_o(s[2]), .Cout_o(cout[2]), .ovf_o(ovf[2]));

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic res_t model(logic [7:0] x, logic [7:0] y, logic ci, logic sb_);
    logic [7:0] yy;
    logic [8:0] full;
    res_t r;
    yy = sb_ ? ~y : y;
    full = {1'b0, x} + {1'b0, yy} + {8'd0, sb_ | ci};
    r.s = full[7:0];
    r.c = full[8];
    r.v = (x[7] == yy[7]) && (full[7] != x[7]);
    return r;
  endfunction

  task automatic op(int k, logic [7:0] x, logic [7:0] y, logic ci, logic sb_, int hold);
    int t;
    int lat;
    res_t e;
    t = 0;
    while (!in_ready[k] && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("in_ready_wait", {31'd0, in_ready[k]}, 32'd1);
    a = x;
    b = y;
    cin = ci;
    sub = sb_;
    in_valid[k] = 1'b1;
    sb.push_back(model(x, y, ci, sb_));
    @(negedge clk);
    acc_cyc = cyc;
    in_valid[k] = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    cin = 1'($urandom);
    sub = 1'($urandom);
    lat = 0;
    while (!out_valid[k] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, nn[k]);
    e = sb.pop_front();
    chk("sum", {24'd0, s[k]}, {24'd0, e.s});
    chk("cout", {31'd0, cout[k]}, {31'd0, e.c});
    chk("ovf", {31'd0, ovf[k]}, {31'd0, e.v});
    if (hold > 0) begin
      out_ready = 1'b0;
      repeat (hold) begin
        @(negedge clk);
        chk("hold_state", {s[k], cout[k], ovf[k], out_valid[k], in_ready[k]}, {e.s, e.c, e.v, 1'b1, 1'b0});
      end
      out_ready = 1'b1;
    end
    @(negedge clk);
    chk("ready_after_hs", {in_ready[k], out_valid[k]}, 32'b10);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) in_valid[i] = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {in_ready[0], in_ready[1], in_ready[2]}, 32'b111);
    chk("rst_valid", {out_valid[0], out_valid[1], out_valid[2]}, 32'b0);
    chk("rst_s", s[0], 32'd0);
    chk("rst_flags", {cout[0], ovf[0]}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    op(0, 8'hFF, 8'h01, 1'b0, 1'b0, 0);
    op(0, 8'h7F, 8'h00, 1'b1, 1'b0, 0);
    op(0, 8'h80, 8'h01, 1'b1, 1'b1, 0);
    op(0, 8'h05, 8'h07, 1'b0, 1'b1, 5);
    op(0, 8'h3C, 8'h5A, 1'b0, 1'b0, 0);
    prev_acc = acc_cyc;
    op(0, 8'hC3, 8'h11, 1'b1, 1'b1, 0);
    chk("throughput", acc_cyc - prev_acc, 6);
    a = 8'h44;
    b = 8'h22;
    sub = 1'b0;
    cin = 1'b0;
    in_valid[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_out", {s[0], cout[0], ovf[0], out_valid[0], in_ready[0]}, 32'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    op(0, 8'h10, 8'h20, 1'b0, 1'b0, 0);
    for (int i = 0; i < 1000; i++)
      op((i % 2) ? 2 : 1, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 0);
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
